// File: rtl/gsim_pkg.sv
// Shared constants, FSM encoding and the shift-add helper for the GSIM residual checker.
package gsim_pkg;

  localparam int          N    = 16;
  localparam int          FRAC = 16;
  localparam int          RW   = 40;
  localparam logic [31:0] TOL  = 32'h0000_0400;

  localparam int unsigned C_DIAG = 20;
  localparam int unsigned C_OFF1 = 13;
  localparam int unsigned C_OFF2 = 6;
  localparam int unsigned C_OFF3 = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_CHECK,
    ST_REPORT
  } state_t;

  // Constant coefficients only, so this collapses to a handful of shifted adds.
  function automatic logic signed [RW-1:0] shadd(input logic signed [RW-1:0] v,
                                                 input int unsigned k);
    logic signed [RW-1:0] acc;
    acc = '0;
    for (int b = 0; b < 5; b++) begin
      if (k[b]) acc = acc + (v <<< b);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gsim_row_residual.sv
// Two-stage row evaluator: stage 1 registers x_i, neighbour sums and b_i; stage 2 forms
// |(b_i<<FRAC) - (20x_i - 13s1 + 6s2 - s3)|, saturates it to 32 bits and flags rows over TOL.
module gsim_row_residual
  import gsim_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 row_vld,
  input  logic [3:0]           row_idx,
  input  logic signed [RW-1:0] x_i,
  input  logic signed [RW-1:0] s1,
  input  logic signed [RW-1:0] s2,
  input  logic signed [RW-1:0] s3,
  input  logic [15:0]          b_i,
  output logic                 res_vld,
  output logic [3:0]           res_idx,
  output logic [31:0]          abs_res,
  output logic                 exceed
);

  logic                 st1_vld;
  logic [3:0]           st1_idx;
  logic signed [RW-1:0] st1_x, st1_s1, st1_s2, st1_s3, st1_b;
  logic signed [RW-1:0] ax, r;
  logic [RW-1:0]        mag;
  logic [31:0]          sat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st1_vld <= 1'b0;
      st1_idx <= '0;
      st1_x   <= '0;
      st1_s1  <= '0;
      st1_s2  <= '0;
      st1_s3  <= '0;
      st1_b   <= '0;
    end else begin
      st1_vld <= row_vld;
      st1_idx <= row_idx;
      st1_x   <= x_i;
      st1_s1  <= s1;
      st1_s2  <= s2;
      st1_s3  <= s3;
      st1_b   <= {{(RW-16){b_i[15]}}, b_i};
    end
  end

  always_comb begin
    ax  = shadd(st1_x, C_DIAG) - shadd(st1_s1, C_OFF1)
        + shadd(st1_s2, C_OFF2) - shadd(st1_s3, C_OFF3);
    r   = (st1_b <<< FRAC) - ax;
    mag = r[RW-1] ? -r : r;
    sat = (|mag[RW-1:32]) ? 32'hFFFF_FFFF : mag[31:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_vld <= 1'b0;
      res_idx <= '0;
      abs_res <= '0;
      exceed  <= 1'b0;
    end else begin
      res_vld <= st1_vld;
      res_idx <= st1_idx;
      abs_res <= sat;
      exceed  <= sat > TOL;
    end
  end

endmodule

// File: rtl/gsim_residual_checker.sv
// Snoops b into a ping-pong buffer, collects 16 x words, checks r = (b<<16) - A*x row by row.
// done pulses 19 cycles after x_15 is captured; stray or overflowing words set sticky proto_err.
module gsim_residual_checker
  import gsim_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_en,
  input  logic [15:0] b_in,
  input  logic        out_valid,
  input  logic [31:0] x_out,
  output logic        done,
  output logic        pass,
  output logic [4:0]  fail_count,
  output logic [3:0]  first_fail,
  output logic [31:0] max_abs_res,
  output logic        proto_err
);

  state_t      state, state_nxt;
  logic [15:0] b_mem [2][N];
  logic [31:0] x_mem [N];
  logic        wr_bank, rd_bank;
  logic [1:0]  full;
  logic [3:0]  wr_idx, x_idx;
  logic [4:0]  issue_cnt;
  logic        b_ok, b_drop, x_take, x_drop, x_last;

  logic                 row_vld, res_vld, exceed;
  logic [3:0]           row_idx, res_idx;
  logic [31:0]          abs_res;
  logic signed [RW-1:0] xi, s1, s2, s3;
  int                   row_int;

  logic [4:0]  acc_fail;
  logic [3:0]  acc_first;
  logic [31:0] acc_max;

  assign b_ok   = in_en && !full[wr_bank];
  assign b_drop = in_en && full[wr_bank];
  assign x_last = x_take && (x_idx == 4'(N-1));

  always_comb begin
    state_nxt = state;
    x_take    = 1'b0;
    x_drop    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (out_valid) begin
          if (full[rd_bank]) begin
            x_take    = 1'b1;
            state_nxt = ST_COLLECT;
          end else begin
            x_drop = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        x_take = out_valid;
        if (out_valid && x_idx == 4'(N-1)) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        x_drop = out_valid;
        if (res_vld && res_idx == 4'(N-1)) state_nxt = ST_REPORT;
      end
      ST_REPORT: begin
        x_drop    = out_valid;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  function automatic logic signed [RW-1:0] xat(input int j);
    if (j < 0 || j >= N) return '0;
    return {{(RW-32){x_mem[j[3:0]][31]}}, x_mem[j[3:0]]};
  endfunction

  assign row_vld = (state == ST_CHECK) && !issue_cnt[4];
  assign row_idx = issue_cnt[3:0];
  assign row_int = int'(row_idx);

  always_comb begin
    xi = xat(row_int);
    s1 = xat(row_int - 1) + xat(row_int + 1);
    s2 = xat(row_int - 2) + xat(row_int + 2);
    s3 = xat(row_int - 3) + xat(row_int + 3);
  end

  gsim_row_residual u_row (
    .clk     (clk),
    .reset_n (reset_n),
    .row_vld (row_vld),
    .row_idx (row_idx),
    .x_i     (xi),
    .s1      (s1),
    .s2      (s2),
    .s3      (s3),
    .b_i     (b_mem[rd_bank][row_idx]),
    .res_vld (res_vld),
    .res_idx (res_idx),
    .abs_res (abs_res),
    .exceed  (exceed)
  );

  // Payload storage carries no reset; validity is tracked by full/x_idx.
  always_ff @(posedge clk) begin
    if (b_ok)   b_mem[wr_bank][wr_idx] <= b_in;
    if (x_take) x_mem[x_idx]           <= x_out;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      full        <= '0;
      wr_idx      <= '0;
      x_idx       <= '0;
      issue_cnt   <= '0;
      acc_fail    <= '0;
      acc_first   <= '0;
      acc_max     <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_count  <= '0;
      first_fail  <= '0;
      max_abs_res <= '0;
      proto_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;

      if (b_ok) begin
        wr_idx <= wr_idx + 4'd1;
        if (wr_idx == 4'(N-1)) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
      end
      if (b_drop || x_drop) proto_err <= 1'b1;

      if (x_take) x_idx <= x_idx + 4'd1;

      if (x_last) begin
        issue_cnt <= '0;
        acc_fail  <= '0;
        acc_first <= '0;
        acc_max   <= '0;
      end else if (row_vld) begin
        issue_cnt <= issue_cnt + 5'd1;
      end

      if (res_vld) begin
        if (exceed) begin
          acc_fail <= acc_fail + 5'd1;
          if (acc_fail == 5'd0) acc_first <= res_idx;
        end
        if (abs_res > acc_max) acc_max <= abs_res;
      end

      if (state == ST_REPORT) begin
        done          <= 1'b1;
        pass          <= (acc_fail == 5'd0);
        fail_count    <= acc_fail;
        first_fail    <= acc_first;
        max_abs_res   <= acc_max;
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

endmodule

// File: tb/tb_gsim_residual_checker.sv
// Scoreboard bench: a reference banded-matrix model predicts each report when its x stream ends.
module tb_gsim_residual_checker;

  typedef logic [15:0][15:0] bvec_t;
  typedef logic [15:0][31:0] xvec_t;
  typedef struct {
    logic        pass;
    logic [4:0]  fc;
    logic [3:0]  ff;
    logic [31:0] mx;
    int          cap;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n, in_en, out_valid;
  logic [15:0] b_in;
  logic [31:0] x_out;
  logic        done, pass, proto_err;
  logic [4:0]  fail_count;
  logic [3:0]  first_fail;
  logic [31:0] max_abs_res;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;
  exp_t  sb[$];
  bvec_t bq[$];

  gsim_residual_checker dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_en       (in_en),
    .b_in        (b_in),
    .out_valid   (out_valid),
    .x_out       (x_out),
    .done        (done),
    .pass        (pass),
    .fail_count  (fail_count),
    .first_fail  (first_fail),
    .max_abs_res (max_abs_res),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input bvec_t b, input xvec_t x);
    exp_t   e;
    longint a, r;
    int     d, c;
    logic [31:0] m;
    e.pass = 1'b1; e.fc = '0; e.ff = '0; e.mx = '0; e.cap = 0;
    for (int i = 0; i < 16; i++) begin
      a = 0;
      for (int j = 0; j < 16; j++) begin
        d = (i > j) ? i - j : j - i;
        c = (d == 0) ? 20 : (d == 1) ? -13 : (d == 2) ? 6 : (d == 3) ? -1 : 0;
        a += longint'(c) * longint'(signed'(x[j]));
      end
      r = longint'(signed'(b[i])) * 65536 - a;
      if (r < 0) r = -r;
      m = (r > 64'sh0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : r[31:0];
      if (m > e.mx) e.mx = m;
      if (r > 1024) begin
        if (e.fc == 0) e.ff = 4'(i);
        e.fc = e.fc + 5'd1;
        e.pass = 1'b0;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("latency", cyc - e.cap, 19);
        check("pass", pass, e.pass);
        check("fail_count", fail_count, e.fc);
        check("first_fail", first_fail, e.ff);
        check("max_abs_res", max_abs_res, e.mx);
      end
    end
  end

  task automatic send_b(input bvec_t b, input bit keep);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_en = 1'b1;
      b_in  = b[i];
    end
    @(negedge clk);
    in_en = 1'b0;
    if (keep) bq.push_back(b);
  endtask

  task automatic send_x(input xvec_t x);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      out_valid = 1'b1;
      x_out     = x[i];
    end
    @(negedge clk);
    out_valid = 1'b0;
    if (bq.size() == 0) begin
      check("b_available", 0, 1);
    end else begin
      e     = model(bq.pop_front(), x);
      e.cap = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    check("drain", sb.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_fail_count"}, fail_count, 0);
    check({tag, "_first_fail"}, first_fail, 0);
    check({tag, "_max"}, max_abs_res, 0);
    check({tag, "_proto_err"}, proto_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bvec_t bz, b2, br;
    xvec_t xz, x1, x3, xs, xf;
    int    b2i [16] = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};

    for (int i = 0; i < 16; i++) begin
      bz[i] = '0;
      xz[i] = '0;
      b2[i] = 16'(b2i[i]);
      x1[i] = 32'h0001_0000;
      xs[i] = 32'(65536 + int'($urandom_range(0, 4095)) - 2048);
      xf[i] = $urandom;
      br[i] = 16'($urandom);
    end
    x3    = x1;
    x3[5] = 32'h0001_0100;

    reset_n = 1'b0; in_en = 1'b0; out_valid = 1'b0; b_in = '0; x_out = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;

    send_b(bz, 1'b1);
    send_x(xz);
    drain();

    send_b(b2, 1'b1);
    send_x(x1);
    drain();
    check("t2_pass", pass, 1);
    check("t2_max", max_abs_res, 0);

    send_b(b2, 1'b1);
    send_x(x3);
    drain();
    check("t3_pass", pass, 0);
    check("t3_fail_count", fail_count, 5);
    check("t3_first_fail", first_fail, 3);
    check("t3_max", max_abs_res, 32'h1400);

    send_b(b2, 1'b1);
    fork
      send_x(xs);
      send_b(br, 1'b1);
    join
    drain();
    send_x(xf);
    drain();
    check("t4_proto_err", proto_err, 0);

    send_b(b2, 1'b1);
    send_b(bz, 1'b1);
    send_b(br, 1'b0);
    check("t5_proto_err", proto_err, 1);
    send_x(x1);
    drain();
    check("t5_first_pass", pass, 1);
    send_x(xz);
    drain();
    check("t5_second_pass", pass, 1);

    send_b(b2, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      out_valid = 1'b1;
      x_out     = x1[i];
    end
    @(negedge clk);
    x_out = x1[8];
    #2 reset_n = 1'b0;
    #1 check_all_zero("midreset");
    out_valid = 1'b0;
    bq.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    send_b(b2, 1'b1);
    send_x(x1);
    drain();
    check("t6_pass", pass, 1);
    check("t6_proto_err", proto_err, 0);

    @(negedge clk);
    out_valid = 1'b1;
    x_out     = 32'h1234_5678;
    @(negedge clk);
    out_valid = 1'b0;
    @(negedge clk);
    check("stray_x_proto_err", proto_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
